// File: rtl/audio_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// audio_pingpong_ctrl
//
// Keeps the two-half (ping-pong) sample buffer ahead of the I2S player. The
// controller requests a block of HALF_WORDS samples from the upstream source,
// streams it into the free half of the buffer RAM, and tracks which halves
// hold fresh data. The player's buffer-empty / buffer-select strobes come
// from the BCLK domain and are resynchronised here.
//
// Optional feature (compile-time macro AUDIO_PINGPONG_WDOG_EN):
//   source inactivity watchdog. While requesting or filling, WDOG_CYCLES
//   consecutive cycles without a transfer abort the block, return to IDLE
//   and raise the sticky wdog_err_o. Without the macro wdog_err_o is 0 and
//   FILL waits for the source indefinitely.
//
// Ports
//   clk, reset_n        master_clock, synchronous active-low reset
//   play_i, stop_i      single-cycle start / abort commands
//   src_req_o           one-cycle pulse: request one HALF_WORDS block
//   src_abort_o         one-cycle pulse: abandon the outstanding block
//   src_valid_i/_data_i source word handshake (word moves on valid & ready)
//   src_ready_o         controller accepts a word (high only in FILL)
//   ram_we_o/_waddr_o/_wdata_o  buffer RAM write port, waddr MSB = half
//   player_empty_i/_sel_i       player status, BCLK domain
//   player_filled_o     buffer-filled indication for the selected half
//   busy_o              controller not IDLE
//   underrun_o          one-cycle pulse per underrun
//   underrun_cnt_o      saturating underrun count
//   wdog_err_o          sticky source-timeout flag
// ---------------------------------------------------------------------------
module audio_pingpong_ctrl #(
  parameter int ADDR_BITS   = 9,
  parameter int HALF_WORDS  = 512,
  parameter int UCNT_W      = 8,
  parameter int WDOG_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 play_i,
  input  logic                 stop_i,
  output logic                 src_req_o,
  output logic                 src_abort_o,
  input  logic                 src_valid_i,
  input  logic [15:0]          src_data_i,
  output logic                 src_ready_o,
  output logic                 ram_we_o,
  output logic [ADDR_BITS:0]   ram_waddr_o,
  output logic [15:0]          ram_wdata_o,
  input  logic                 player_empty_i,
  input  logic                 player_sel_i,
  output logic                 player_filled_o,
  output logic                 busy_o,
  output logic                 underrun_o,
  output logic [UCNT_W-1:0]    underrun_cnt_o,
  output logic                 wdog_err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_PLAY
  } state_t;

  localparam logic [ADDR_BITS-1:0] LAST_WORD = ADDR_BITS'(HALF_WORDS - 1);

  state_t               state;
  logic                 half;       // half currently being filled
  logic [ADDR_BITS-1:0] wcnt;       // word index inside that half
  logic [1:0]           full;       // per-half "holds unplayed data"
  logic [1:0]           full_nxt;

  logic empty_meta, empty_s, empty_s_d;
  logic sel_meta, sel_s;

  logic xfer, last_xfer, empty_rise, underrun_hit;
  logic in_fetch, wd_fire, abort_now;

  // -------------------------------------------------------------------------
  // Player status crossing from BCLK: plain 2-flop synchronisers, plus one
  // more stage on empty to find its rising edge.
  // -------------------------------------------------------------------------
  // NOTE: every register is written with <= so all flops sample the values
  // from before the edge; a blocking = here would collapse the synchroniser.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      empty_meta <= 1'b0;
      empty_s    <= 1'b0;
      empty_s_d  <= 1'b0;
      sel_meta   <= 1'b0;
      sel_s      <= 1'b0;
    end else begin
      empty_meta <= player_empty_i;
      empty_s    <= empty_meta;
      empty_s_d  <= empty_s;
      sel_meta   <= player_sel_i;
      sel_s      <= sel_meta;
    end
  end

  // -------------------------------------------------------------------------
  // Source handshake and RAM write port (combinational pass-through).
  // -------------------------------------------------------------------------
  assign src_ready_o = (state == S_FILL);
  assign xfer        = src_valid_i & src_ready_o;
  assign last_xfer   = xfer & (wcnt == LAST_WORD);

  assign ram_we_o    = xfer;
  assign ram_waddr_o = {half, wcnt};
  assign ram_wdata_o = src_data_i;

  // Player events are meaningless while stopped.
  assign empty_rise   = empty_s & ~empty_s_d & (state != S_IDLE);
  // sel_s already points at the half the player has moved on to.
  assign underrun_hit = empty_rise & ~full[sel_s];

  assign in_fetch = (state == S_REQ) || (state == S_FILL);

  // -------------------------------------------------------------------------
  // Optional source watchdog.
  // -------------------------------------------------------------------------
`ifdef AUDIO_PINGPONG_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;

  // Counts idle fetch cycles; any transfer or leaving REQ/FILL restarts it,
  // so it is already 0 on every entry to REQ.
  assign wd_fire = in_fetch & ~xfer & (wd_cnt == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wd_cnt     <= '0;
      wdog_err_o <= 1'b0;
    end else begin
      if (in_fetch && !xfer && !abort_now) wd_cnt <= wd_cnt + 1'b1;
      else                                  wd_cnt <= '0;

      if (wd_fire)
        wdog_err_o <= 1'b1;
      else if (state == S_IDLE && play_i && !stop_i)
        wdog_err_o <= 1'b0;
    end
  end
`else
  assign wd_fire    = 1'b0;
  assign wdog_err_o = 1'b0;
`endif

  assign abort_now = stop_i | wd_fire;

  // -------------------------------------------------------------------------
  // Next value of the per-half full flags. A half completing on the same
  // cycle the player releases it keeps its set: that data is new.
  // -------------------------------------------------------------------------
  // NOTE: full_nxt gets its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    full_nxt = full;
    if (empty_rise) full_nxt[~sel_s] = 1'b0;
    if (last_xfer)  full_nxt[half]   = 1'b1;
    if (abort_now)  full_nxt         = 2'b00;
  end

  // -------------------------------------------------------------------------
  // Sequencer with registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      half            <= 1'b0;
      wcnt            <= '0;
      full            <= 2'b00;
      src_req_o       <= 1'b0;
      src_abort_o     <= 1'b0;
      player_filled_o <= 1'b0;
      busy_o          <= 1'b0;
      underrun_o      <= 1'b0;
      underrun_cnt_o  <= '0;
    end else begin
      src_req_o       <= 1'b0;
      src_abort_o     <= 1'b0;
      underrun_o      <= 1'b0;
      full            <= full_nxt;
      // full_nxt is all-zero whenever the sequencer is (or is going) idle.
      player_filled_o <= full_nxt[sel_s];

      if (underrun_hit) begin
        underrun_o <= 1'b1;
        if (underrun_cnt_o != '1) underrun_cnt_o <= underrun_cnt_o + 1'b1;
      end

      if (xfer) wcnt <= (wcnt == LAST_WORD) ? '0 : wcnt + 1'b1;

      if (abort_now) begin
        // A word on the stop cycle is still written, but its half is not
        // marked full and the block is abandoned.
        state       <= S_IDLE;
        busy_o      <= 1'b0;
        wcnt        <= '0;
        src_abort_o <= in_fetch;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (play_i) begin
              state     <= S_REQ;
              half      <= 1'b0;
              wcnt      <= '0;
              src_req_o <= 1'b1;
              busy_o    <= 1'b1;
            end
          end
          S_REQ: begin
            state <= S_FILL;
          end
          S_FILL: begin
            if (last_xfer) begin
              if (!full[~half]) begin
                state     <= S_REQ;
                half      <= ~half;
                src_req_o <= 1'b1;
              end else begin
                state <= S_PLAY;
              end
            end
          end
          S_PLAY: begin
            if (!full[0] || !full[1]) begin
              state     <= S_REQ;
              wcnt      <= '0;
              src_req_o <= 1'b1;
              // Both drained: refill the one the player will read first.
              if (!full[0] && !full[1]) half <= sel_s;
              else                      half <= full[0];
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for audio_pingpong_ctrl with HALF_WORDS=4, ADDR_BITS=2,
// UCNT_W=2. Stimulus pushes expected RAM writes, underrun counts and abort
// events into queues; a negedge monitor pops and compares them whenever the
// DUT presents the corresponding output.
// ---------------------------------------------------------------------------
module tb_audio_pingpong_ctrl;

  localparam int AB = 2;
  localparam int HW = 4;
  localparam int UW = 2;

  logic          clk;
  logic          reset_n;
  logic          play_i, stop_i;
  logic          src_req_o, src_abort_o;
  logic          src_valid_i;
  logic [15:0]   src_data_i;
  logic          src_ready_o;
  logic          ram_we_o;
  logic [AB:0]   ram_waddr_o;
  logic [15:0]   ram_wdata_o;
  logic          player_empty_i, player_sel_i;
  logic          player_filled_o, busy_o, underrun_o;
  logic [UW-1:0] underrun_cnt_o;
  logic          wdog_err_o;

  audio_pingpong_ctrl #(
    .ADDR_BITS  (AB),
    .HALF_WORDS (HW),
    .UCNT_W     (UW),
    .WDOG_CYCLES(1000)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .play_i         (play_i),
    .stop_i         (stop_i),
    .src_req_o      (src_req_o),
    .src_abort_o    (src_abort_o),
    .src_valid_i    (src_valid_i),
    .src_data_i     (src_data_i),
    .src_ready_o    (src_ready_o),
    .ram_we_o       (ram_we_o),
    .ram_waddr_o    (ram_waddr_o),
    .ram_wdata_o    (ram_wdata_o),
    .player_empty_i (player_empty_i),
    .player_sel_i   (player_sel_i),
    .player_filled_o(player_filled_o),
    .busy_o         (busy_o),
    .underrun_o     (underrun_o),
    .underrun_cnt_o (underrun_cnt_o),
    .wdog_err_o     (wdog_err_o)
  );

`ifdef AUDIO_PINGPONG_WDOG_EN
  // Second instance with a short timeout, source permanently silent.
  logic          w_reset_n, w_play;
  logic          w_req, w_abort, w_ready, w_we, w_filled, w_busy, w_ur, w_wdog;
  logic [AB:0]   w_waddr;
  logic [15:0]   w_wdata;
  logic [UW-1:0] w_ucnt;

  audio_pingpong_ctrl #(
    .ADDR_BITS  (AB),
    .HALF_WORDS (HW),
    .UCNT_W     (UW),
    .WDOG_CYCLES(16)
  ) dut_wd (
    .clk            (clk),
    .reset_n        (w_reset_n),
    .play_i         (w_play),
    .stop_i         (1'b0),
    .src_req_o      (w_req),
    .src_abort_o    (w_abort),
    .src_valid_i    (1'b0),
    .src_data_i     (16'h0000),
    .src_ready_o    (w_ready),
    .ram_we_o       (w_we),
    .ram_waddr_o    (w_waddr),
    .ram_wdata_o    (w_wdata),
    .player_empty_i (1'b0),
    .player_sel_i   (1'b0),
    .player_filled_o(w_filled),
    .busy_o         (w_busy),
    .underrun_o     (w_ur),
    .underrun_cnt_o (w_ucnt),
    .wdog_err_o     (w_wdog)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AB:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t           wr_q[$];
  logic [UW-1:0] ur_q[$];
  int            abort_q[$];
  int            n_cmp;
  int            n_fail;
  int            req_seen;
  wr_t           mon_wr;
  logic [UW-1:0] mon_ur;
  int            mon_tok;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ------------------------------ monitor ----------------------------------
  always @(negedge clk) begin
    if (ram_we_o) begin
      if (wr_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL ram_write: unexpected write addr 0x%0h data 0x%0h, expected none",
                 ram_waddr_o, ram_wdata_o);
      end else begin
        mon_wr = wr_q.pop_front();
        check("ram_waddr", 32'(ram_waddr_o), 32'(mon_wr.addr));
        check("ram_wdata", 32'(ram_wdata_o), 32'(mon_wr.data));
      end
    end
    if (src_req_o) req_seen++;
    if (underrun_o) begin
      if (ur_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL underrun_pulse: got unexpected pulse (cnt %0d), expected none",
                 underrun_cnt_o);
      end else begin
        mon_ur = ur_q.pop_front();
        check("underrun_cnt_at_pulse", 32'(underrun_cnt_o), 32'(mon_ur));
      end
    end
    if (src_abort_o) begin
      if (abort_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL abort_pulse: got unexpected abort, expected none");
      end else begin
        mon_tok = abort_q.pop_front();
        check("abort_busy_filled_ready", 32'({busy_o, player_filled_o, src_ready_o}), 32'(0));
      end
    end
  end

  // ------------------------------ drivers ----------------------------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_play();
    play_i = 1'b1;
    tick();
    play_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
  endtask

  task automatic push_wr(input int base, input int first, input int n);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = (AB+1)'(base + i);
      e.data = 16'(first + i);
      wr_q.push_back(e);
    end
  endtask

  // Offers words first, first+1, ... until n of them have been accepted.
  task automatic stream(input int first, input int n);
    int   sent   = 0;
    int   budget = 100;
    logic rdy;
    src_valid_i = 1'b1;
    src_data_i  = 16'(first);
    while (sent < n && budget > 0) begin
      @(negedge clk);
      rdy = src_ready_o;
      @(posedge clk);
      #1;
      budget--;
      if (rdy) begin
        sent++;
        src_data_i = 16'(first + sent);
      end
    end
    src_valid_i = 1'b0;
    if (sent < n) begin
      n_cmp++;
      n_fail++;
      $display("FAIL stream_timeout: accepted %0d words, expected %0d", sent, n);
    end
  endtask

  task automatic set_sel(input logic v);
    player_sel_i = v;
    tick(4);
  endtask

  // Long enough for the 2-flop synchroniser and the edge detector.
  task automatic empty_pulse();
    player_empty_i = 1'b1;
    tick(3);
    player_empty_i = 1'b0;
    tick(4);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1);
  end

  // ------------------------------ stimulus ---------------------------------
  initial begin
    n_cmp = 0; n_fail = 0; req_seen = 0;
    reset_n = 1'b0; play_i = 1'b0; stop_i = 1'b0;
    src_valid_i = 1'b0; src_data_i = 16'h0000;
    player_empty_i = 1'b0; player_sel_i = 1'b0;
`ifdef AUDIO_PINGPONG_WDOG_EN
    w_reset_n = 1'b0; w_play = 1'b0;
`endif
    tick(3);

    check("rst_busy",     32'(busy_o), 32'(0));
    check("rst_filled",   32'(player_filled_o), 32'(0));
    check("rst_ready",    32'(src_ready_o), 32'(0));
    check("rst_req",      32'(src_req_o), 32'(0));
    check("rst_abort",    32'(src_abort_o), 32'(0));
    check("rst_ucnt",     32'(underrun_cnt_o), 32'(0));
    check("rst_wdog",     32'(wdog_err_o), 32'(0));
    reset_n = 1'b1;
    tick();

    // Priming: half 0 then half 1.
    push_wr(0, 'h0001, 4);
    push_wr(4, 'h0005, 4);
    pulse_play();
    check("busy_after_play", 32'(busy_o), 32'(1));
    check("req_pulse_in_req", 32'(src_req_o), 32'(1));
    check("ready_in_req", 32'(src_ready_o), 32'(0));
    stream('h0001, 4);
    check("filled_after_half0", 32'(player_filled_o), 32'(1));
    stream('h0005, 4);
    tick();
    check("ready_in_play", 32'(src_ready_o), 32'(0));
    check("req_count_prime", 32'(req_seen), 32'(2));

    // play_i is ignored when already running.
    pulse_play();
    tick(3);
    check("play_ignored_req", 32'(req_seen), 32'(2));
    check("play_ignored_busy", 32'(busy_o), 32'(1));

    // Player moves to half 1 and releases half 0: refill without underrun.
    set_sel(1'b1);
    check("filled_sel1", 32'(player_filled_o), 32'(1));
    empty_pulse();
    check("req_count_refill0", 32'(req_seen), 32'(3));
    check("ucnt_no_underrun", 32'(underrun_cnt_o), 32'(0));
    check("filled_still_half1", 32'(player_filled_o), 32'(1));

    // Source stalls; player comes back to half 0 before it is refilled.
    set_sel(1'b0);
    check("filled_sel0_pending", 32'(player_filled_o), 32'(0));
    ur_q.push_back(UW'(1));
    empty_pulse();
    check("ucnt_first_underrun", 32'(underrun_cnt_o), 32'(1));
    check("filled_during_underrun", 32'(player_filled_o), 32'(0));
    push_wr(0, 'h0011, 4);
    stream('h0011, 4);
    check("filled_after_refill0", 32'(player_filled_o), 32'(1));
    push_wr(4, 'h0015, 4);
    stream('h0015, 4);
    tick();
    check("req_count_after_refill", 32'(req_seen), 32'(4));

    // Saturation of the 2-bit underrun counter.
    empty_pulse();
    set_sel(1'b1);
    for (int k = 0; k < 4; k++) begin
      int e;
      e = (k + 2 > 3) ? 3 : k + 2;
      ur_q.push_back(UW'(e));
      empty_pulse();
    end
    check("ucnt_saturated", 32'(underrun_cnt_o), 32'(3));
    check("filled_starved", 32'(player_filled_o), 32'(0));

    // Refill half 1, start half 0, stop after two words.
    push_wr(4, 'h0021, 4);
    stream('h0021, 4);
    check("filled_half1_back", 32'(player_filled_o), 32'(1));
    push_wr(0, 'h0025, 2);
    stream('h0025, 2);
    abort_q.push_back(1);
    pulse_stop();
    check("stop_busy", 32'(busy_o), 32'(0));
    check("stop_filled", 32'(player_filled_o), 32'(0));
    check("stop_ready", 32'(src_ready_o), 32'(0));
    check("stop_abort", 32'(src_abort_o), 32'(1));
    tick();
    check("abort_one_cycle", 32'(src_abort_o), 32'(0));

    // Restart at address 0; stop collides with the last word of the half.
    set_sel(1'b0);
    push_wr(0, 'h0031, 3);
    pulse_play();
    stream('h0031, 3);
    push_wr(3, 'h0034, 1);
    abort_q.push_back(1);
    src_valid_i = 1'b1;
    src_data_i  = 16'h0034;
    stop_i      = 1'b1;
    tick();
    stop_i      = 1'b0;
    src_valid_i = 1'b0;
    check("stopwin_filled", 32'(player_filled_o), 32'(0));
    check("stopwin_busy", 32'(busy_o), 32'(0));
    tick();
    check("req_count_total", 32'(req_seen), 32'(7));

`ifdef AUDIO_PINGPONG_WDOG_EN
    w_reset_n = 1'b1;
    tick();
    check("wd_rst_err", 32'(w_wdog), 32'(0));
    w_play = 1'b1;
    tick();
    w_play = 1'b0;
    tick(15);
    check("wd_before_timeout_err", 32'(w_wdog), 32'(0));
    check("wd_before_timeout_busy", 32'(w_busy), 32'(1));
    tick();
    check("wd_timeout_err", 32'(w_wdog), 32'(1));
    check("wd_timeout_abort", 32'(w_abort), 32'(1));
    check("wd_timeout_busy", 32'(w_busy), 32'(0));
    w_reset_n = 1'b0;
    tick();
    check("wd_reset_clears", 32'(w_wdog), 32'(0));
`endif

    tick(5);
    check("wr_queue_drained", 32'(wr_q.size()), 32'(0));
    check("ur_queue_drained", 32'(ur_q.size()), 32'(0));
    check("abort_queue_drained", 32'(abort_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_pingpong_ctrl.md
Name: audio_pingpong_ctrl

Overview:
Sequences the two-half (ping-pong) sample buffer that feeds the I2S player.
- Requests 16-bit sample blocks from the upstream sample source and writes them into the free half of the buffer RAM.
- Drives the player's buffer-filled input and consumes its buffer-empty / buffer-select outputs.
- Sits in the codec subsystem between the source (file reader) and the I2S player. Runs on master_clock; player signals cross in from the BCLK domain.

Parameters:
- ADDR_BITS, 9, address bits per buffer half.
- HALF_WORDS, 512, 16-bit words per half; must be ≤ 2**ADDR_BITS.
- UCNT_W, 8, width of the saturating underrun counter.
- WDOG_CYCLES, 1000000, source inactivity timeout. Used only with the optional feature.

Ports:
- clk  in  1  master_clock.
- reset_n  in  1  synchronous, active-low reset.
- play_i  in  1  pulse; start playback from IDLE.
- stop_i  in  1  pulse; abort playback from any state.
- src_req_o  out  1  one-cycle pulse requesting one block of HALF_WORDS words.
- src_abort_o  out  1  one-cycle pulse; abandon the outstanding block.
- src_valid_i  in  1  source word valid.
- src_data_i  in  16  source sample.
- src_ready_o  out  1  controller accepts a word.
- ram_we_o  out  1  buffer RAM write enable.
- ram_waddr_o  out  ADDR_BITS+1  RAM write address; MSB = half.
- ram_wdata_o  out  16  RAM write data.
- player_empty_i  in  1  player buffer-empty (BCLK domain).
- player_sel_i  in  1  player buffer-select (BCLK domain).
- player_filled_o  out  1  to player buffer-filled input.
- busy_o  out  1  high when not IDLE.
- underrun_o  out  1  one-cycle pulse per underrun.
- underrun_cnt_o  out  UCNT_W  saturating underrun count.
- wdog_err_o  out  1  sticky source-timeout flag; 0 without the optional feature.

Behaviour:
- Reset (synchronous, reset_n=0 at clk edge):
  - All outputs 0, state IDLE, full[1:0]=0, counters 0, synchronizers cleared.
- CDC: player_empty_i and player_sel_i each pass through 2-flop synchronizers (empty_s, sel_s).
  - empty_rise = empty_s & ~empty_s_d.
- Transfer: a word transfers when src_valid_i & src_ready_o.
  - Same cycle: ram_we_o=1, ram_waddr_o={half, wcnt}, ram_wdata_o=src_data_i (combinational pass-through).
  - wcnt increments; wraps to 0 after HALF_WORDS-1.
- FSM states: IDLE, REQ, FILL, PLAY.
  - IDLE: play_i → REQ with fill half=0.
  - REQ: pulse src_req_o for 1 cycle → FILL. src_ready_o=0 in REQ.
  - FILL: src_ready_o=1.
    - On the transfer with wcnt=HALF_WORDS-1: set full[half], ready drops next cycle.
    - Next state: if full[~half]=0 → REQ with half=~half; else → PLAY.
  - PLAY: if any full[h]=0 → REQ with half=h. If both halves are empty, pick h=sel_s.
  - stop_i in any state: → IDLE, full cleared, player_filled_o=0 next cycle, src_ready_o=0.
    - src_abort_o pulses if stop_i arrives in REQ or FILL.
    - stop_i wins over a simultaneous last-word transfer; that word is still written.
- player_filled_o (registered) = full[sel_s] & (state≠IDLE).
  - Priming writes half 0 then half 1, so filled rises only after half 0 is full.
- On empty_rise (player toggled sel_s to the new half):
  - Clear full[~sel_s], i.e. the half just drained.
  - If full[sel_s]=0: underrun_o pulse; underrun_cnt_o += 1, saturating at all-ones.
  - Clear and set on the same cycle for the same half: set wins (fresh data just landed).
- Ignore play_i when not IDLE. Ignore empty_rise in IDLE.
- busy_o = (state≠IDLE).

Optional Feature:
- Macro: AUDIO_PINGPONG_WDOG_EN.
- Defined:
  - A counter runs in REQ/FILL; it resets on every transfer and on entry to REQ.
  - Reaching WDOG_CYCLES: set wdog_err_o (sticky until reset or play_i), pulse src_abort_o, go to IDLE with full cleared.
- Undefined: no counter logic; wdog_err_o tied to 0; FILL waits indefinitely.

Test Plan:
- HALF_WORDS=4; play_i; source streams 8 words 0x0001..0x0008 →
  - two src_req_o pulses; RAM writes addr 0..3 = 1..4 and addr 4..7 = 5..8.
  - player_filled_o=1 after the 4th word; state PLAY.
- In PLAY, toggle player_sel_i 0→1, then pulse player_empty_i →
  - full[0] cleared; src_req_o for half 0; refill writes addr 0..3.
  - underrun_cnt_o stays 0.
- Hold src_valid_i=0 during refill; toggle sel back to 0 with an empty pulse →
  - underrun_o pulse; underrun_cnt_o=1; player_filled_o=0 until refill completes.
- UCNT_W=2, force 5 underruns → underrun_cnt_o saturates at 3.
- stop_i mid-FILL (after 2 of 4 words) →
  - src_abort_o pulse; IDLE next cycle; player_filled_o=0, src_ready_o=0.
  - play_i then restarts writing at addr 0.
- AUDIO_PINGPONG_WDOG_EN, WDOG_CYCLES=16, source silent after play_i →
  - at cycle 16 of inactivity: wdog_err_o=1, src_abort_o pulse, busy_o=0.
  - reset_n=0 clears wdog_err_o.
